kronos_mem_arbiter: RTL and testbench



---
 rtl/kronos_types.sv | 22 ++
 rtl/kronos_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_kronos_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kronos_types.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_types (package)
//  Description : Shared types for the Kronos memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package kronos_types;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ARB_IDLE,
        BUSY_I = ARB_BUSY_I,
        BUSY_D = ARB_BUSY_D
    } arb_state_e;

    localparam int unsigned STREAK_W = 4;

endpackage
`default_nettype wire

// File: rtl/kronos_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_mem_arbiter
//  Description : Shares one memory port between instruction and data sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module kronos_mem_arbiter
    import kronos_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_gnt,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_wr_mask,
    input  logic        data_rd_req,
    input  logic        data_wr_req,
    output logic [31:0] data_rd_data,
    output logic        data_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_gnt
);

    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [3:0]          wr_mask_q, wr_mask_d;
    logic                we_q, we_d;
    logic                w_data_pend;
    logic                w_take_data;

    assign w_data_pend = data_rd_req | data_wr_req;
    // Data wins unless the fetch has already been passed over STARVE_LIMIT times.
    assign w_take_data = w_data_pend && (!instr_req || (streak_q < c_STREAK_MAX));

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_mask_d = wr_mask_q;
        we_d      = we_q;
        case (state_q)
            IDLE: begin
                if (w_take_data) begin
                    state_d   = BUSY_D;
                    addr_d    = data_addr;
                    we_d      = data_wr_req;
                    wr_data_d = data_wr_data;
                    wr_mask_d = data_wr_req ? data_wr_mask : 4'h0;
                end else if (instr_req) begin
                    state_d   = BUSY_I;
                    addr_d    = instr_addr;
                    we_d      = 1'b0;
                    wr_data_d = 32'h0;
                    wr_mask_d = 4'h0;
                end
            end
            BUSY_I: begin
                if (mem_gnt) begin
                    state_d  = IDLE;
                    streak_d = '0;
                end
            end
            BUSY_D: begin
                if (mem_gnt) begin
                    state_d = IDLE;
                    if (!instr_req) begin
                        streak_d = '0;
                    end else if (streak_q < c_STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            addr_q    <= 32'h0;
            wr_data_q <= 32'h0;
            wr_mask_q <= 4'h0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            we_q      <= we_d;
        end
    end

    assign mem_req      = (state_q != IDLE);
    assign mem_addr     = addr_q;
    assign mem_wr_data  = wr_data_q;
    assign mem_wr_mask  = wr_mask_q;
    assign mem_we       = we_q;
    assign instr_gnt    = (state_q == BUSY_I) && mem_gnt;
    assign data_gnt     = (state_q == BUSY_D) && mem_gnt;
    assign instr_data   = mem_rd_data;
    assign data_rd_data = mem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_kronos_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kronos_mem_arbiter
//  Description : Scoreboard bench for kronos_mem_arbiter (STARVE_LIMIT = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kronos_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr, data_addr, data_wr_data;
    logic        instr_req, data_rd_req, data_wr_req;
    logic [3:0]  data_wr_mask;
    logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        instr_gnt, data_gnt, mem_we, mem_req, mem_gnt;
    logic [3:0]  mem_wr_mask;

    int   checks = 0;
    int   errors = 0;
    int   gnt_delay = 0;
    int   stall_cnt;
    txn_t sb[$];
    txn_t mon_exp;
    logic [31:0] mon_rd;
    logic prev_gnt = 1'b0;

    always #5 clk = ~clk;

    kronos_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_gnt(instr_gnt),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_rd_data(data_rd_data), .data_gnt(data_gnt),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_we(mem_we), .mem_req(mem_req), .mem_rd_data(mem_rd_data), .mem_gnt(mem_gnt)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: grants after gnt_delay wait cycles of mem_req.
    always @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= 0;
        else if (!mem_req || mem_gnt) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
    end
    assign mem_gnt     = mem_req && (stall_cnt == gnt_delay);
    assign mem_rd_data = mem_val(mem_addr);

    function automatic void push_txn(input logic is_d, input logic [31:0] addr,
                                     input logic we, input logic [31:0] wdata,
                                     input logic [3:0] mask);
        txn_t t;
        t.is_d = is_d; t.addr = addr; t.we = we; t.wdata = wdata; t.mask = mask;
        t.rdata = mem_val(addr);
        sb.push_back(t);
    endfunction

    // Scoreboard: every requester grant pops and checks the next expected transaction.
    always @(negedge clk) begin
        if (instr_gnt || data_gnt) begin
            checks++;
            if (prev_gnt) begin
                errors++;
                $display("FAIL sb_back_to_back: grant in consecutive cycles at %0t", $time);
            end
            checks++;
            if (instr_gnt && data_gnt) begin
                errors++;
                $display("FAIL sb_both_gnt: instr_gnt=1 data_gnt=1 at %0t", $time);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: grant instr=%0b data=%0b addr=%h, want none", instr_gnt, data_gnt, mem_addr);
            end else begin
                mon_exp = sb.pop_front();
                mon_rd  = data_gnt ? data_rd_data : instr_data;
                if (data_gnt !== mon_exp.is_d || mem_addr !== mon_exp.addr ||
                    mem_we !== mon_exp.we || mem_wr_mask !== mon_exp.mask ||
                    (mon_exp.we && mem_wr_data !== mon_exp.wdata) || mon_rd !== mon_exp.rdata) begin
                    errors++;
                    $display("FAIL sb_txn: got d=%0b addr=%h we=%0b mask=%h wd=%h rd=%h, want d=%0b addr=%h we=%0b mask=%h wd=%h rd=%h",
                             data_gnt, mem_addr, mem_we, mem_wr_mask, mem_wr_data, mon_rd,
                             mon_exp.is_d, mon_exp.addr, mon_exp.we, mon_exp.mask, mon_exp.wdata, mon_exp.rdata);
                end
            end
        end
        prev_gnt = instr_gnt | data_gnt;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
        instr_addr = 32'h0; data_addr = 32'h0; data_wr_data = 32'h0; data_wr_mask = 4'h0;
        gnt_delay = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d expected grants never seen, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_wr_mask, mem_addr, mem_wr_data, instr_gnt, data_gnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b we=%0b mask=%h addr=%h wd=%h ig=%0b dg=%0b, want all 0",
                     mem_req, mem_we, mem_wr_mask, mem_addr, mem_wr_data, instr_gnt, data_gnt);
        end
        instr_req = 1'b1; instr_addr = 32'h44;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: mem_req=%0b while in reset, want 0", mem_req);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: mem_req=%0b with no request, want 0", mem_req);
        end
    endtask

    task automatic test_lone_fetch();
        do_reset();
        instr_addr = 32'h100; instr_req = 1'b1;
        push_txn(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_we, instr_gnt, data_gnt, instr_data} !==
            {1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL fetch_issue: req=%0b addr=%h we=%0b ig=%0b dg=%0b data=%h, want 1 00000100 0 1 0 deadbeef",
                     mem_req, mem_addr, mem_we, instr_gnt, data_gnt, instr_data);
        end
        instr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, instr_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_bubble: req=%0b ig=%0b, want 0 0", mem_req, instr_gnt);
        end
        check_sb_empty("fetch");
    endtask

    task automatic test_simultaneous();
        do_reset();
        instr_addr = 32'h104; instr_req = 1'b1;
        data_addr = 32'h200; data_wr_data = 32'h55AA; data_wr_mask = 4'h3; data_wr_req = 1'b1;
        push_txn(1'b1, 32'h200, 1'b1, 32'h55AA, 4'h3);
        push_txn(1'b0, 32'h104, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_we, mem_wr_mask, mem_wr_data, data_gnt} !==
            {1'b1, 32'h200, 1'b1, 4'h3, 32'h55AA, 1'b1}) begin
            errors++;
            $display("FAIL simul_data_first: req=%0b addr=%h we=%0b mask=%h wd=%h dg=%0b, want 1 00000200 1 3 000055aa 1",
                     mem_req, mem_addr, mem_we, mem_wr_mask, mem_wr_data, data_gnt);
        end
        data_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, instr_gnt, data_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL simul_bubble: req=%0b ig=%0b dg=%0b, want 0 0 0", mem_req, instr_gnt, data_gnt);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_we, instr_gnt} !== {1'b1, 32'h104, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL simul_fetch_next: req=%0b addr=%h we=%0b ig=%0b, want 1 00000104 0 1",
                     mem_req, mem_addr, mem_we, instr_gnt);
        end
        instr_req = 1'b0;
        @(negedge clk);
        check_sb_empty("simul");
    endtask

    task automatic test_starvation();
        int n = 0;
        do_reset();
        instr_addr = 32'h108; instr_req = 1'b1;
        data_addr = 32'h300; data_rd_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_txn(1'b1, 32'h300, 1'b0, 32'h0, 4'h0);
            push_txn(1'b1, 32'h300, 1'b0, 32'h0, 4'h0);
            push_txn(1'b0, 32'h108, 1'b0, 32'h0, 4'h0);
        end
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (instr_gnt || data_gnt) n++;
        end
        instr_req = 1'b0; data_rd_req = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL starve_count: saw %0d grants within budget, want 6", n);
        end
        @(negedge clk);
        @(negedge clk);
        check_sb_empty("starve");
    endtask

    task automatic test_mem_stall();
        int n = 0;
        do_reset();
        gnt_delay = 5;
        data_addr = 32'h400; data_rd_req = 1'b1;
        push_txn(1'b1, 32'h400, 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr, instr_gnt, data_gnt} !== {1'b1, 32'h400, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: req=%0b addr=%h ig=%0b dg=%0b, want 1 00000400 0 0",
                         k, mem_req, mem_addr, instr_gnt, data_gnt);
            end
            if (k == 0) begin
                instr_addr = 32'h10C; instr_req = 1'b1;
                push_txn(1'b0, 32'h10C, 1'b0, 32'h0, 4'h0);
            end
        end
        @(negedge clk);
        checks++;
        if ({data_gnt, mem_addr} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL stall_release: dg=%0b addr=%h, want 1 00000400", data_gnt, mem_addr);
        end
        data_rd_req = 1'b0;
        @(negedge clk);
        gnt_delay = 0;
        for (int c = 0; c < 10 && n < 1; c++) begin
            @(negedge clk);
            if (instr_gnt) n++;
        end
        instr_req = 1'b0;
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL stall_fetch_after: saw %0d fetch grants, want 1", n);
        end
        @(negedge clk);
        check_sb_empty("stall");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        instr_addr = 32'h110; instr_req = 1'b1;
        data_addr = 32'h800; data_rd_req = 1'b1;
        push_txn(1'b1, 32'h800, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        gnt_delay = 4;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, data_gnt} !== {1'b1, 32'h800, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_busy: req=%0b addr=%h dg=%0b, want 1 00000800 0", mem_req, mem_addr, data_gnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_we, data_gnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: req=%0b addr=%h we=%0b dg=%0b, want all 0", mem_req, mem_addr, mem_we, data_gnt);
        end
        @(negedge clk);
        gnt_delay = 0;
        check_sb_empty("rstmid_pre");
        // Cleared streak means two more data grants before the fetch.
        push_txn(1'b1, 32'h800, 1'b0, 32'h0, 4'h0);
        push_txn(1'b1, 32'h800, 1'b0, 32'h0, 4'h0);
        push_txn(1'b0, 32'h110, 1'b0, 32'h0, 4'h0);
        rst = 1'b0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (instr_gnt || data_gnt) n++;
        end
        instr_req = 1'b0; data_rd_req = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL rstmid_resume: saw %0d grants, want 3", n);
        end
        @(negedge clk);
        check_sb_empty("rstmid");
    endtask

    task automatic test_rd_wr_both();
        do_reset();
        data_addr = 32'h700; data_wr_data = 32'h12345678; data_wr_mask = 4'hF;
        data_rd_req = 1'b1; data_wr_req = 1'b1;
        push_txn(1'b1, 32'h700, 1'b1, 32'h12345678, 4'hF);
        @(negedge clk);
        checks++;
        if ({mem_we, mem_wr_mask, data_gnt} !== {1'b1, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL rdwr_as_write: we=%0b mask=%h dg=%0b, want 1 f 1", mem_we, mem_wr_mask, data_gnt);
        end
        data_rd_req = 1'b0; data_wr_req = 1'b0;
        @(negedge clk);
        check_sb_empty("rdwr");
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
        instr_addr = 32'h0; data_addr = 32'h0; data_wr_data = 32'h0; data_wr_mask = 4'h0;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_mem_stall();
        test_reset_mid();
        test_rd_wr_both();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
